arb_sched8: RTL and testbench
=============================

ARB_SCHED8 -- requirements
Module: arb_sched8

Interface
REQ-001 Parameter MAX_HOLD, default 16: maximum consecutive grant cycles per owner; 0 disables the timeout.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  8  request vector, one bit per requester; bit 7 is the highest fixed priority.
REQ-005 mode  input  1  0 = fixed priority, 1 = rotating (round-robin) priority.
REQ-006 en  input  1  arbitration enable; new grants are issued only while high.
REQ-007 gnt  output  8  one-hot grant vector, registered.
REQ-008 gnt_id  output  3  binary index of the current owner, registered; 3'b000 when no grant.
REQ-009 gnt_valid  output  1  high while any grant is active.
REQ-010 idle  output  1  high when no grant is active; always the complement of gnt_valid.
REQ-011 timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Function
REQ-012 States SHALL be S_IDLE (no owner, arbitrating) and S_GRANT (owner holds the resource).
REQ-013 In S_IDLE with en=1 and req!=0, the next edge SHALL load the winner into gnt/gnt_id, set gnt_valid=1, clear the hold counter and enter S_GRANT; req-to-gnt latency SHALL be exactly 1 cycle.
REQ-014 In S_IDLE with en=0 or req=0, state and outputs SHALL stay idle (gnt=0, gnt_id=0, idle=1).
REQ-015 mode=0: the winner SHALL be the highest-index asserted req bit.
REQ-016 mode=1: priority SHALL be descending from (last_id-1) mod 8, wrapping 0->7; last_id SHALL be the most recent granted index, reset to 0, so the first order is 7..0.
REQ-017 mode SHALL be sampled only in S_IDLE; a change during S_GRANT SHALL not affect the current grant.
REQ-018 In S_GRANT, the hold counter SHALL increment every cycle; its width SHALL be clog2(MAX_HOLD+1) and it SHALL not wrap.
REQ-019 In S_GRANT, when req[gnt_id]=0 the next edge SHALL clear gnt, gnt_id and gnt_valid and return to S_IDLE with no timeout pulse.
REQ-020 In S_GRANT with MAX_HOLD>0, when the hold counter equals MAX_HOLD-1 and req[gnt_id]=1, the next edge SHALL release the grant, return to S_IDLE and assert timeout for exactly 1 cycle.
REQ-021 Every release SHALL be followed by at least one cycle with gnt=0 before the next grant, so back-to-back owners are separated by one idle cycle.
REQ-022 Deasserting en during S_GRANT SHALL not revoke the current grant; it SHALL only block the next grant.
REQ-023 Requests from non-owners during S_GRANT SHALL be ignored until S_IDLE.
REQ-024 gnt SHALL never have more than one bit set; gnt_id SHALL always encode the set bit of gnt.
REQ-025 last_id SHALL update on every grant in both modes.

Reset
REQ-026 On rst_n=0, asynchronously: state=S_IDLE, gnt=8'h00, gnt_id=3'b000, gnt_valid=0, idle=1, timeout=0, hold counter=0, last_id=3'b000.
REQ-027 Reset asserted during S_GRANT SHALL drop the grant immediately, without waiting for a clock edge.

Structure
REQ-028 The state encoding and the requester count (8) SHALL live in a shared package, arb_pkg.
REQ-029 Winner selection SHALL be a combinational sub-module, prio_sel8: 8-bit request plus 3-bit rotation start in, 3-bit index plus none flag out. It SHALL reuse the 8-to-3 priority-encoding behaviour, so that index 0 and no-request are distinguished by the flag.

Verification
REQ-030 Fixed mode: req=8'b0010_0110 in S_IDLE -> 1 cycle later gnt=8'b0010_0000, gnt_id=5, idle=0.
REQ-031 Round-robin mode: all req=8'hFF held, each owner drops its req after 2 grant cycles and reasserts it -> grant order 7,6,5,4,3,2,1,0,7, with one idle cycle between grants.
REQ-032 Timeout with MAX_HOLD=4: req[3] held high -> gnt_id=3 for exactly 4 cycles, then gnt=0 with timeout=1 for 1 cycle; with req[3] still high, gnt_id=3 returns after the idle cycle.
REQ-033 Idle with no request: req=0 -> idle=1, gnt=0, gnt_id=0 indefinitely; req=8'h01 -> gnt_id=0, gnt_valid=1.
REQ-034 Reset mid-grant: rst_n driven low in the 2nd cycle of S_GRANT -> gnt=0 asynchronously; after release, req=8'hFF in mode=1 -> first grant is gnt_id=7.
REQ-035 Enable gating: en=0 with req=8'h80 -> no grant; en dropped during a grant -> grant held until req[7] falls.

Source files
------------

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared constants, FSM state encoding and the 8-to-3
//               priority-encoder helper for the arb_sched8 arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

   localparam int N_REQ = 8;
   localparam int ID_W  = 3;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   // Highest-index-wins encoder; MSB of the result is the "no request" flag
   // so that index 0 and an empty vector stay distinguishable.
   function automatic logic [ID_W:0] prio_enc8(input logic [N_REQ-1:0] v);
      logic [ID_W:0] r;
      r = {1'b1, {ID_W{1'b0}}};
      for (int i = 0; i < N_REQ; i++) begin
         if (v[i]) r = {1'b0, ID_W'(i)};
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/prio_sel8.sv
`default_nettype none
// ============================================================================
// Module      : prio_sel8
// Description : Combinational winner selection. Priority descends from
//               i_start, wrapping 0 -> 7. i_start = 7 gives fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module prio_sel8
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] i_req,
   input  logic [ID_W-1:0]  i_start,
   output logic [ID_W-1:0]  o_idx,
   output logic             o_none
);

   logic [N_REQ-1:0] w_rot;
   logic [ID_W:0]    w_enc;

   // Rotate so that requester i_start lands on bit 7, then encode highest-first
   // and undo the rotation on the resulting index.
   always_comb begin
      w_rot = '0;
      for (int j = 0; j < N_REQ; j++) begin
         w_rot[j] = i_req[ID_W'(i_start + ID_W'(j) + ID_W'(1))];
      end
      w_enc  = prio_enc8(w_rot);
      o_none = w_enc[ID_W];
      o_idx  = w_enc[ID_W] ? '0 : ID_W'(i_start + w_enc[ID_W-1:0] + ID_W'(1));
   end

endmodule
`default_nettype wire

// File: rtl/arb_sched8.sv
`default_nettype none
// ============================================================================
// Module      : arb_sched8
// Description : 8-requester arbiter with fixed or round-robin priority,
//               enable gating, and optional maximum-hold timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_sched8
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             mode,
   input  logic             en,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  gnt_id,
   output logic             gnt_valid,
   output logic             idle,
   output logic             timeout
);

   // A zero-width counter is illegal, so the disabled-timeout case keeps 1 bit.
   localparam int                 c_HOLD_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam bit                 c_TO_EN     = (MAX_HOLD > 0);
   localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
   localparam logic [c_HOLD_W-1:0] c_HOLD_MAX  = '1;

   state_t              r_state;
   logic [N_REQ-1:0]    r_gnt;
   logic [ID_W-1:0]     r_gnt_id;
   logic                r_gnt_valid;
   logic                r_timeout;
   logic [c_HOLD_W-1:0] r_hold;
   logic [ID_W-1:0]     r_last_id;

   logic [ID_W-1:0]     w_start;
   logic [ID_W-1:0]     w_win_id;
   logic                w_none;
   logic                w_owner_req;

   // Rotation start: fixed mode always starts at 7, round-robin just below last owner.
   always_comb begin
      w_start     = mode ? ID_W'(r_last_id - ID_W'(1)) : ID_W'(N_REQ - 1);
      w_owner_req = req[r_gnt_id];
   end

   prio_sel8 u_sel (
      .i_req   (req),
      .i_start (w_start),
      .o_idx   (w_win_id),
      .o_none  (w_none)
   );

   // Arbitration FSM; every output is registered here. Releases always land in
   // S_IDLE, which guarantees a gnt=0 cycle between consecutive owners.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_gnt       <= '0;
         r_gnt_id    <= '0;
         r_gnt_valid <= 1'b0;
         r_timeout   <= 1'b0;
         r_hold      <= '0;
         r_last_id   <= '0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (en && !w_none) begin
                  r_state     <= S_GRANT;
                  r_gnt       <= N_REQ'(1) << w_win_id;
                  r_gnt_id    <= w_win_id;
                  r_gnt_valid <= 1'b1;
                  r_hold      <= '0;
                  r_last_id   <= w_win_id;
               end
            end
            S_GRANT: begin
               if (!w_owner_req || (c_TO_EN && (r_hold == c_HOLD_LAST))) begin
                  r_state     <= S_IDLE;
                  r_gnt       <= '0;
                  r_gnt_id    <= '0;
                  r_gnt_valid <= 1'b0;
                  r_hold      <= '0;
                  r_timeout   <= w_owner_req;
               end else if (r_hold != c_HOLD_MAX) begin
                  r_hold <= r_hold + c_HOLD_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign gnt       = r_gnt;
   assign gnt_id    = r_gnt_id;
   assign gnt_valid = r_gnt_valid;
   assign idle      = ~r_gnt_valid;
   assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_arb_sched8.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb_sched8
// Description : Self-checking bench for arb_sched8 (MAX_HOLD = 4), directed
//               scenarios followed by randomized traffic against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_sched8;

   localparam int MAXH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req;
   logic       mode;
   logic       en;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;
   logic       idle;
   logic       timeout;

   int errors = 0;
   int checks = 0;

   // Reference model: owner index (-1 = none), cycles held, last owner, pulse.
   int m_owner = -1;
   int m_hold  = 0;
   int m_last  = 0;
   int m_to    = 0;

   int rr_order [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

   arb_sched8 #(.MAX_HOLD(MAXH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .mode      (mode),
      .en        (en),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .idle      (idle),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_hold  = 0;
      m_last  = 0;
      m_to    = 0;
   endtask

   // Next state of the model from the inputs currently applied.
   task automatic model_edge();
      int w;
      int s;
      int idx;
      if (m_owner < 0) begin
         m_to = 0;
         if (en && req != 8'h00) begin
            w = -1;
            if (!mode) begin
               for (int i = 0; i < 8; i++) if (req[i]) w = i;
            end else begin
               s = (m_last + 7) % 8;
               for (int k = 0; k < 8; k++) begin
                  idx = (s - k + 8) % 8;
                  if (w < 0 && req[idx]) w = idx;
               end
            end
            m_owner = w;
            m_hold  = 0;
            m_last  = w;
         end
      end else if (!req[m_owner]) begin
         m_owner = -1;
         m_to    = 0;
      end else if (MAXH > 0 && m_hold == MAXH - 1) begin
         m_owner = -1;
         m_to    = 1;
      end else begin
         m_hold++;
         m_to = 0;
      end
   endtask

   task automatic check_all();
      logic [7:0] e_gnt;
      logic [7:0] e_id;
      e_gnt = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
      e_id  = (m_owner < 0) ? 8'h00 : 8'(m_owner);
      chk("gnt",       gnt,               e_gnt);
      chk("gnt_id",    {5'd0, gnt_id},    e_id);
      chk("gnt_valid", {7'd0, gnt_valid}, {7'd0, m_owner >= 0});
      chk("idle",      {7'd0, idle},      {7'd0, m_owner < 0});
      chk("timeout",   {7'd0, timeout},   8'(m_to));
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   // Called just after a rising edge; pulls reset low between edges.
   task automatic async_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("async_gnt", gnt, 8'h00);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 8'h00;
      mode  = 1'b0;
      en    = 1'b1;
      #3;
      check_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Idle with no request
      for (int i = 0; i < 3; i++) step();
      chk("idle_noreq", {7'd0, idle}, 8'h01);

      // Fixed priority winner
      req = 8'b0010_0110;
      step();
      chk("fixed_gnt", gnt, 8'b0010_0000);
      chk("fixed_id", {5'd0, gnt_id}, 8'd5);
      req = 8'h00;
      step();
      step();

      // Round-robin rotation, two grant cycles per owner
      async_reset();
      mode = 1'b1;
      req  = 8'hFF;
      for (int g = 0; g < 9; g++) begin
         step();
         chk("rr_order", {5'd0, gnt_id}, 8'(rr_order[g]));
         step();
         req[rr_order[g]] = 1'b0;
         step();
         chk("rr_gap", gnt, 8'h00);
         req = 8'hFF;
      end

      // Timeout with a continuously held request
      async_reset();
      mode = 1'b0;
      req  = 8'h08;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("to_hold", {5'd0, gnt_id}, 8'd3);
      end
      step();
      chk("to_pulse", {7'd0, timeout}, 8'd1);
      chk("to_rel", gnt, 8'h00);
      step();
      chk("to_regrant", {5'd0, gnt_id}, 8'd3);
      chk("to_clear", {7'd0, timeout}, 8'd0);
      req = 8'h00;
      step();

      // Reset in the second grant cycle, then round-robin restarts at 7
      mode = 1'b1;
      req  = 8'hFF;
      step();
      step();
      async_reset();
      step();
      chk("rst_first", {5'd0, gnt_id}, 8'd7);
      req = 8'h00;
      step();
      step();

      // Enable gating
      mode = 1'b0;
      en   = 1'b0;
      req  = 8'h80;
      for (int i = 0; i < 3; i++) step();
      chk("en_block", gnt, 8'h00);
      en = 1'b1;
      step();
      chk("en_grant", gnt, 8'h80);
      en = 1'b0;
      step();
      step();
      chk("en_hold", gnt, 8'h80);
      req = 8'h00;
      step();
      chk("en_rel", gnt, 8'h00);
      en = 1'b1;

      // Lowest requester alone
      req = 8'h01;
      step();
      chk("req0_id", {5'd0, gnt_id}, 8'd0);
      chk("req0_valid", {7'd0, gnt_valid}, 8'd1);

      // Randomized traffic with sticky requests and rare resets
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 9) < 3) begin
            if ($urandom_range(0, 3) == 0) req = 8'h00;
            else if ($urandom_range(0, 1) == 0) req = 8'($urandom) & 8'($urandom);
            else req = 8'($urandom);
         end
         if ($urandom_range(0, 7) == 0) mode = 1'($urandom_range(0, 1));
         en = ($urandom_range(0, 5) != 0);
         if ($urandom_range(0, 99) == 0) async_reset();
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
